inst_rom_responder: RTL and testbench

- Instruction-memory responder for the core's fetch port: answers rom_ce/rom_addr with a 32-bit instruction word in the same cycle, which is the combinational-read timing the IF/ID register expects.
- Contains a byte-serial program loader with a valid/ready handshake. The loader assembles big-endian bytes into words, writes them from word 0 upward and keeps a running checksum.
- Sits beside the core at SoC top. Loader is driven by a host/UART bridge.
- busy_o is intended to hold the core in reset while loading.

---
 rtl/inst_rom_responder.sv | 149 ++++++++++++++
 tb/tb_inst_rom_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_responder.sv
// Instruction ROM for the core fetch port with zero-latency reads, plus a
// byte-serial program loader that fills it big-endian from word 0 upward.
module inst_rom_responder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W:0]   ld_len_i,
  input  logic              ld_abort_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic              busy_o,
  output logic [31:0]       ld_sum_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   ptr_reg;
  logic [1:0]          byte_cnt_reg;
  logic [23:0]         asm_reg;
  logic [ADDR_W:0]     len_reg;
  logic [31:0]         sum_reg;
  logic                ready_reg;
  logic                done_reg;
  logic                busy_reg;

  logic [31:0]         mem [DEPTH];

  logic                byte_fire;
  logic                word_fire;
  logic [31:0]         word_next;
  logic [ADDR_W:0]     ptr_inc;
  logic                last_word;
  logic [ADDR_W:0]     len_clamped;
  logic                fetch_hit;
  logic                unused_addr_bits;

  // Abort outranks a coincident byte, so a byte is only taken when no abort.
  assign byte_fire   = (state_reg == S_LOAD) && ready_reg && ld_valid_i && !ld_abort_i;
  assign word_fire   = byte_fire && (byte_cnt_reg == 2'd3);
  assign word_next   = {asm_reg, ld_byte_i};
  assign ptr_inc     = {1'b0, ptr_reg} + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word   = (ptr_inc == len_reg);
  assign len_clamped = (ld_len_i > DEPTH_L) ? DEPTH_L : ld_len_i;

  // Fetch returns a NOP whenever the loader owns the memory or the PC is out of range.
  assign fetch_hit  = rom_ce_i && (state_reg == S_IDLE) &&
                      (rom_addr_i[31:ADDR_W+2] == '0);
  assign rom_data_o = fetch_hit ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;
  assign unused_addr_bits = ^rom_addr_i[1:0];

  always_ff @(posedge clk) begin
    if (word_fire) begin
      mem[ptr_reg] <= word_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      len_reg      <= '0;
      sum_reg      <= '0;
      ready_reg    <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (ld_start_i) begin
            len_reg      <= len_clamped;
            ptr_reg      <= '0;
            byte_cnt_reg <= '0;
            asm_reg      <= '0;
            sum_reg      <= '0;
            busy_reg     <= 1'b1;
            if (len_clamped == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
              ready_reg <= 1'b0;
            end else begin
              state_reg <= S_LOAD;
              ready_reg <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (ld_abort_i) begin
            state_reg    <= S_IDLE;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            byte_cnt_reg <= '0;
            asm_reg      <= '0;
          end else if (byte_fire) begin
            if (byte_cnt_reg == 2'd3) begin
              sum_reg      <= sum_reg + word_next;
              byte_cnt_reg <= '0;
              asm_reg      <= '0;
              if (last_word) begin
                // Pointer stays on the final word so it never reaches len.
                state_reg <= S_DONE;
                ready_reg <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                ptr_reg <= ptr_inc[ADDR_W-1:0];
              end
            end else begin
              asm_reg      <= {asm_reg[15:0], ld_byte_i};
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready_o = ready_reg;
  assign ld_done_o  = done_reg;
  assign busy_o     = busy_reg;
  assign ld_sum_o   = sum_reg;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Scoreboard bench for inst_rom_responder: stimulus queues expected done sums
// and fetch words, a negedge monitor pops and compares them.
module tb_inst_rom_responder;

  localparam int AW = 4;

  logic              clk;
  logic              rst;
  logic              rom_ce_i;
  logic [31:0]       rom_addr_i;
  logic [31:0]       rom_data_o;
  logic              ld_start_i;
  logic [AW:0]       ld_len_i;
  logic              ld_abort_i;
  logic [7:0]        ld_byte_i;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic              ld_done_o;
  logic              busy_o;
  logic [31:0]       ld_sum_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_done[$];
  exp_t exp_fetch[$];

  logic [31:0] prog [16];

  inst_rom_responder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ld_start_i (ld_start_i),
    .ld_len_i   (ld_len_i),
    .ld_abort_i (ld_abort_i),
    .ld_byte_i  (ld_byte_i),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .ld_done_o  (ld_done_o),
    .busy_o     (busy_o),
    .ld_sum_o   (ld_sum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a done pulse or an enabled fetch is the DUT presenting a result.
  always @(negedge clk) begin
    if (ld_done_o) begin
      if (exp_done.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_done.pop_front();
        chk(e.name, ld_sum_o, e.val);
      end
    end
    if (rom_ce_i) begin
      if (exp_fetch.size() == 0) chk("unexpected_fetch", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_fetch.pop_front();
        chk(e.name, rom_data_o, e.val);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
    exp_fetch.push_back('{name, exp});
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    tick();
    rom_ce_i   = 1'b0;
    rom_addr_i = 32'h0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    ld_byte_i  = b;
    ld_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      acc = ld_ready_o;
      tick();
      if (acc) return;
    end
    chk("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_load(input logic [AW:0] len);
    ld_len_i   = len;
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
  endtask

  task automatic do_load(input string name, input logic [AW:0] len, input int nwords,
                         input bit toggle, input logic [31:0] exp_sum);
    exp_done.push_back('{name, exp_sum});
    start_load(len);
    chk({name, "_busy"}, {31'd0, busy_o}, 32'd1);
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(prog[w][31-8*k -: 8]);
        if (w == nwords - 1 && k == 3) begin
          ld_valid_i = 1'b0;
          chk({name, "_done_hi"}, {31'd0, ld_done_o}, 32'd1);
          chk({name, "_ready_in_done"}, {31'd0, ld_ready_o}, 32'd0);
          tick();
          chk({name, "_done_lo"}, {31'd0, ld_done_o}, 32'd0);
          chk({name, "_idle"}, {31'd0, busy_o}, 32'd0);
        end else if (toggle) begin
          ld_valid_i = 1'b0;
          tick();
        end
      end
    end
  endtask

  initial begin
    logic [31:0] sum16;
    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = 32'h0; ld_start_i = 1'b0;
    ld_len_i = '0; ld_abort_i = 1'b0; ld_byte_i = 8'h0; ld_valid_i = 1'b0;
    #2 rst = 1'b0;
    tick(); tick();
    chk("rst_data", rom_data_o, 32'h0);
    chk("rst_ready", {31'd0, ld_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_sum", ld_sum_o, 32'h0);
    chk("rst_done", {31'd0, ld_done_o}, 32'd0);
    rst = 1'b1;
    tick();

    prog[0] = 32'h34020001;
    prog[1] = 32'h3C031234;
    do_load("load2_sum", 5'd2, 2, 1'b0, 32'h70051235);
    fetch("fetch_w1", 32'h4, 32'h3C031234);
    fetch("fetch_w0", 32'h0, 32'h34020001);

    do_load("load2_toggle_sum", 5'd2, 2, 1'b1, 32'h70051235);
    fetch("toggle_w0", 32'h0, 32'h34020001);
    fetch("toggle_w1_lowbits", 32'h7, 32'h3C031234);

    // Abort on the sixth byte edge with a valid byte present.
    start_load(5'd3);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    ld_byte_i  = 8'h66;
    ld_abort_i = 1'b1;
    tick();
    ld_abort_i = 1'b0;
    ld_valid_i = 1'b0;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_ready", {31'd0, ld_ready_o}, 32'd0);
    chk("abort_sum", ld_sum_o, 32'h11223344);
    fetch("abort_w0", 32'h0, 32'h11223344);
    fetch("abort_w1_kept", 32'h4, 32'h3C031234);

    exp_done.push_back('{"len0_sum", 32'h0});
    start_load(5'd0);
    chk("len0_done_hi", {31'd0, ld_done_o}, 32'd1);
    chk("len0_busy", {31'd0, busy_o}, 32'd1);
    tick();
    chk("len0_done_lo", {31'd0, ld_done_o}, 32'd0);
    chk("len0_idle", {31'd0, busy_o}, 32'd0);
    fetch("len0_w0_kept", 32'h0, 32'h11223344);

    sum16 = 32'h0;
    for (int i = 0; i < 16; i++) begin
      prog[i] = 32'h9E3779B9 * (i + 1);
      sum16   = sum16 + prog[i];
    end
    do_load("len17_sum", 5'd17, 16, 1'b0, sum16);
    fetch("len17_w0", 32'h0, prog[0]);
    fetch("len17_w15", 32'h3C, prog[15]);
    fetch("len17_w15_lowbits", 32'h3F, prog[15]);
    fetch("oob_0x40", 32'h40, 32'h0);
    fetch("oob_high", 32'h1000_0004, 32'h0);

    // Fetch while loading, then asynchronous reset mid-word.
    start_load(5'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    ld_valid_i = 1'b0;
    fetch("fetch_in_load", 32'h0, 32'h0);
    chk("load_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'hCC);
    ld_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, ld_ready_o}, 32'd0);
    chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    fetch("post_rst_w0", 32'h0, prog[0]);
    fetch("post_rst_w1", 32'h4, prog[1]);

    tick(); tick();
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);
    chk("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
